// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
//   Shared constants for the video stream generator: pattern select codes,
//   FSM state encoding and the checker tile size (as a bit index into x/y).
// ----------------------------------------------------------------------------
package video_pkg;

    // pattern_sel encodings
    localparam logic [1:0] PAT_XRAMP   = 2'd0;
    localparam logic [1:0] PAT_YRAMP   = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_CONST   = 2'd3;

    // Checker tiles are 2^CHECKER_SHIFT pixels square
    localparam int CHECKER_SHIFT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_e;

endpackage : video_pkg

// File: rtl/video_pattern_lut.sv
// ----------------------------------------------------------------------------
// video_pattern_lut
//   Combinational test-pattern generator. Maps the (x,y) position of the pixel
//   being emitted to a pixel value; the parent registers the result.
// Ports
//   x_i, y_i  : low PIXEL_WIDTH bits of the pixel position
//   sel_i     : pattern select (PAT_XRAMP/PAT_YRAMP/PAT_CHECKER/PAT_CONST)
//   val_i     : constant value / checker "white" level
//   pix_o     : pixel value
// ----------------------------------------------------------------------------
module video_pattern_lut
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12
) (
    input  logic [PIXEL_WIDTH-1:0] x_i,
    input  logic [PIXEL_WIDTH-1:0] y_i,
    input  logic [1:0]             sel_i,
    input  logic [PIXEL_WIDTH-1:0] val_i,
    output logic [PIXEL_WIDTH-1:0] pix_o
);

    always_comb begin
        pix_o = '0;
        case (sel_i)
            PAT_XRAMP:   pix_o = x_i;
            PAT_YRAMP:   pix_o = y_i;
            PAT_CHECKER: pix_o = (x_i[CHECKER_SHIFT] ^ y_i[CHECKER_SHIFT]) ? val_i : '0;
            default:     pix_o = val_i;
        endcase
    end

endmodule : video_pattern_lut

// File: rtl/video_stream_gen.sv
// ----------------------------------------------------------------------------
// video_stream_gen
//   Programmable de/hs/vs pixel stream source with built-in test patterns.
//   Frame geometry, blanking, de throttling and pattern are sampled into
//   shadow registers at each frame start and held for the whole frame.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : start frames while high; stops at a frame boundary
//   h_active/v_active : frame size (either 0 = no output)
//   h_blank/v_blank : idle cycles after a line / after a frame
//   de_period       : idle cycles between pixels of a line
//   pattern_sel/val : pattern select and constant / checker level
//   do_o/de_o/hs_o/vs_o : registered pixel stream
//   busy_o          : high while a frame (incl. v_blank) is in progress
// ----------------------------------------------------------------------------
module video_stream_gen
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [CNT_WIDTH-1:0]   h_active,
    input  logic [CNT_WIDTH-1:0]   v_active,
    input  logic [CNT_WIDTH-1:0]   h_blank,
    input  logic [CNT_WIDTH-1:0]   v_blank,
    input  logic [3:0]             de_period,
    input  logic [1:0]             pattern_sel,
    input  logic [PIXEL_WIDTH-1:0] pattern_val,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   busy_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   x_q, x_d;
    logic [CNT_WIDTH-1:0]   y_q, y_d;
    logic [3:0]             gap_q, gap_d;
    logic [CNT_WIDTH-1:0]   blank_q, blank_d;
    // Set by the last pixel of a line: the following ACTIVE cycle is the
    // line-exit cycle, where the line/frame decision is taken.
    logic                   exit_q, exit_d;

    // Shadow configuration
    logic [CNT_WIDTH-1:0]   cfg_h_q, cfg_h_d;
    logic [CNT_WIDTH-1:0]   cfg_v_q, cfg_v_d;
    logic [CNT_WIDTH-1:0]   cfg_hb_q, cfg_hb_d;
    logic [CNT_WIDTH-1:0]   cfg_vb_q, cfg_vb_d;
    logic [3:0]             cfg_dp_q, cfg_dp_d;
    logic [1:0]             cfg_sel_q, cfg_sel_d;
    logic [PIXEL_WIDTH-1:0] cfg_val_q, cfg_val_d;

    // Output registers
    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   busy_q, busy_d;

    logic                   start_ok;
    logic                   pix_fire;
    logic                   frame_boundary;
    logic [PIXEL_WIDTH-1:0] pix;

    assign start_ok = enable && (h_active != '0) && (v_active != '0);
    assign pix_fire = (state_q == ST_ACTIVE) && !exit_q && (gap_q == '0);

    video_pattern_lut #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_lut (
        .x_i   (x_q[PIXEL_WIDTH-1:0]),
        .y_i   (y_q[PIXEL_WIDTH-1:0]),
        .sel_i (cfg_sel_q),
        .val_i (cfg_val_q),
        .pix_o (pix)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            gap_q     <= '0;
            blank_q   <= '0;
            exit_q    <= 1'b0;
            cfg_h_q   <= '0;
            cfg_v_q   <= '0;
            cfg_hb_q  <= '0;
            cfg_vb_q  <= '0;
            cfg_dp_q  <= '0;
            cfg_sel_q <= '0;
            cfg_val_q <= '0;
            do_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            gap_q     <= gap_d;
            blank_q   <= blank_d;
            exit_q    <= exit_d;
            cfg_h_q   <= cfg_h_d;
            cfg_v_q   <= cfg_v_d;
            cfg_hb_q  <= cfg_hb_d;
            cfg_vb_q  <= cfg_vb_d;
            cfg_dp_q  <= cfg_dp_d;
            cfg_sel_q <= cfg_sel_d;
            cfg_val_q <= cfg_val_d;
            do_q      <= do_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        gap_d          = gap_q;
        blank_d        = blank_q;
        exit_d         = exit_q;
        cfg_h_d        = cfg_h_q;
        cfg_v_d        = cfg_v_q;
        cfg_hb_d       = cfg_hb_q;
        cfg_vb_d       = cfg_vb_q;
        cfg_dp_d       = cfg_dp_q;
        cfg_sel_d      = cfg_sel_q;
        cfg_val_d      = cfg_val_q;
        frame_boundary = 1'b0;

        case (state_q)
            ST_IDLE: frame_boundary = 1'b1;

            ST_ACTIVE: begin
                if (exit_q) begin
                    exit_d = 1'b0;
                    if (y_q != cfg_v_q - CNT_ONE) begin
                        y_d   = y_q + CNT_ONE;
                        gap_d = '0;
                        if (cfg_hb_q != '0) begin
                            state_d = ST_HBLANK;
                            blank_d = cfg_hb_q - CNT_ONE;
                        end
                    end else if (cfg_vb_q != '0) begin
                        state_d = ST_VBLANK;
                        blank_d = cfg_vb_q - CNT_ONE;
                    end else begin
                        frame_boundary = 1'b1;
                    end
                end else if (pix_fire) begin
                    gap_d = cfg_dp_q;
                    if (x_q == cfg_h_q - CNT_ONE) begin
                        x_d    = '0;
                        exit_d = 1'b1;
                    end else begin
                        x_d = x_q + CNT_ONE;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            ST_HBLANK: begin
                if (blank_q == '0) begin
                    state_d = ST_ACTIVE;
                    gap_d   = '0;
                end else begin
                    blank_d = blank_q - CNT_ONE;
                end
            end

            default: begin // ST_VBLANK
                if (blank_q == '0) frame_boundary = 1'b1;
                else               blank_d = blank_q - CNT_ONE;
            end
        endcase

        // Frame boundary: either launch a new frame with fresh config or idle.
        if (frame_boundary) begin
            if (start_ok) begin
                state_d   = ST_ACTIVE;
                x_d       = '0;
                y_d       = '0;
                gap_d     = '0;
                exit_d    = 1'b0;
                cfg_h_d   = h_active;
                cfg_v_d   = v_active;
                cfg_hb_d  = h_blank;
                cfg_vb_d  = v_blank;
                cfg_dp_d  = de_period;
                cfg_sel_d = pattern_sel;
                cfg_val_d = pattern_val;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered next cycle)
    // ------------------------------------------------------------------
    always_comb begin
        de_d   = pix_fire;
        hs_d   = pix_fire && (x_q == '0);
        vs_d   = pix_fire && (x_q == '0) && (y_q == '0);
        do_d   = pix_fire ? pix : '0;
        busy_d = (state_d != ST_IDLE);
    end

    assign do_o   = do_q;
    assign de_o   = de_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign busy_o = busy_q;

endmodule : video_stream_gen
